// File: rtl/audio_pkg.sv
// Shared types for the audio sample sequencer: sample word, sequencer states and
// a saturating counter helper.
package audio_pkg;

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } seq_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/audio_stream_sequencer_if.sv
// Sample-path signals between the sequencer (master) and the SPI receiver, DSP and
// I2S transmitter around it (slave).
interface audio_stream_sequencer_if;
  import audio_pkg::*;

  logic        rx_valid;
  sample_t     rx_data;
  logic        dsp_in_valid;
  sample_t     dsp_in_data;
  logic        dsp_out_valid;
  sample_t     dsp_out_data;
  logic [5:0]  i2s_bit_number;
  sample_t     i2s_sample;
  logic        i2s_mute;

  modport master (
    input  rx_valid, rx_data, dsp_out_valid, dsp_out_data, i2s_bit_number,
    output dsp_in_valid, dsp_in_data, i2s_sample, i2s_mute
  );

  modport slave (
    output rx_valid, rx_data, dsp_out_valid, dsp_out_data, i2s_bit_number,
    input  dsp_in_valid, dsp_in_data, i2s_sample, i2s_mute
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with flush; read data is show-ahead (head word always on rdata).
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic              serial_clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  sample_t           wdata,
  input  logic              pop,
  output sample_t           rdata,
  output logic              full,
  output logic              empty,
  output logic [LevelW-1:0] level
);

  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  sample_t           mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (level_q == LevelW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge serial_clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge serial_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_stream_sequencer.sv
// Moves samples SPI rx -> FIFO -> DSP -> I2S sample register, with priming, underrun
// muting, overrun dropping, DSP timeout and saturating status counters.
module audio_stream_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PRIME_LEVEL = 4,
  parameter int unsigned FRAME_BITS  = 32,
  parameter int unsigned DSP_TIMEOUT = 64,
  localparam int unsigned LevelW = $clog2(DEPTH) + 1
) (
  input  logic                      serial_clk,
  input  logic                      reset,
  input  logic                      enable,
  audio_stream_sequencer_if.master  bus,
  output logic [1:0]                seq_state,
  output logic [LevelW-1:0]         fifo_level,
  output logic [7:0]                overrun_count,
  output logic [7:0]                underrun_count
);

  localparam int unsigned TimerW = $clog2(DSP_TIMEOUT + 1);

  seq_state_e         state_q;
  logic               outstanding_q, next_valid_q, boundary_q;
  logic [TimerW-1:0]  timer_q;
  sample_t            next_sample_q, dsp_in_data_q, i2s_sample_q;
  logic               dsp_in_valid_q, i2s_mute_q;
  logic [7:0]         overrun_q, underrun_q;

  sample_t            fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               running, timeout_now, dispatch, push, overrun_now;
  logic               boundary_now, frame_edge, level_ok;

  assign running      = enable && (state_q != IDLE);
  assign timeout_now  = outstanding_q && !bus.dsp_out_valid &&
                        (timer_q == TimerW'(DSP_TIMEOUT - 1));
  // A timed-out slot can be reissued on the very edge that abandons it.
  assign dispatch     = running && !fifo_empty && !next_valid_q &&
                        (!outstanding_q || timeout_now);
  assign push         = bus.rx_valid && running && (!fifo_full || dispatch);
  assign overrun_now  = bus.rx_valid && running && fifo_full && !dispatch;
  assign boundary_now = (bus.i2s_bit_number == 6'(FRAME_BITS - 1));
  assign frame_edge   = boundary_now && !boundary_q;
  assign level_ok     = (fifo_level >= LevelW'(PRIME_LEVEL));

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .serial_clk (serial_clk),
    .reset      (reset),
    .flush      (!enable),
    .push       (push),
    .wdata      (bus.rx_data),
    .pop        (dispatch),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      outstanding_q  <= 1'b0;
      next_valid_q   <= 1'b0;
      boundary_q     <= 1'b0;
      timer_q        <= '0;
      next_sample_q  <= '0;
      dsp_in_valid_q <= 1'b0;
      dsp_in_data_q  <= '0;
      i2s_sample_q   <= '0;
      i2s_mute_q     <= 1'b1;
      overrun_q      <= '0;
      underrun_q     <= '0;
    end else begin
      boundary_q     <= boundary_now;
      dsp_in_valid_q <= 1'b0;
      if (!enable) begin
        state_q       <= IDLE;
        outstanding_q <= 1'b0;
        next_valid_q  <= 1'b0;
        timer_q       <= '0;
        i2s_sample_q  <= '0;
        i2s_mute_q    <= 1'b1;
      end else if (state_q == IDLE) begin
        state_q <= PRIME;
      end else begin
        if (overrun_now) overrun_q <= sat_inc(overrun_q);

        if (dispatch) begin
          dsp_in_valid_q <= 1'b1;
          dsp_in_data_q  <= fifo_rdata;
          outstanding_q  <= 1'b1;
          timer_q        <= '0;
        end else if (outstanding_q) begin
          if (bus.dsp_out_valid) begin
            next_sample_q <= bus.dsp_out_data;
            next_valid_q  <= 1'b1;
            outstanding_q <= 1'b0;
          end else if (timeout_now) begin
            outstanding_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        // Uses the registered next_valid, so a same-cycle completion waits a frame.
        if (frame_edge) begin
          if (state_q == RUN && next_valid_q) begin
            i2s_sample_q <= next_sample_q;
            i2s_mute_q   <= 1'b0;
            next_valid_q <= 1'b0;
          end else begin
            i2s_sample_q <= '0;
            i2s_mute_q   <= 1'b1;
            if (state_q == RUN) begin
              underrun_q <= sat_inc(underrun_q);
              state_q    <= UNDERRUN;
            end
          end
        end

        if ((state_q == PRIME || state_q == UNDERRUN) && level_ok && next_valid_q) begin
          state_q <= RUN;
        end
      end
    end
  end

  assign bus.dsp_in_valid = dsp_in_valid_q;
  assign bus.dsp_in_data  = dsp_in_data_q;
  assign bus.i2s_sample   = i2s_sample_q;
  assign bus.i2s_mute     = i2s_mute_q;
  assign seq_state        = state_q;
  assign overrun_count    = overrun_q;
  assign underrun_count   = underrun_q;

endmodule
